// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the FFT frame driver.
package fft_pkg;

  localparam int N     = 64;
  localparam int LOG2N = 6;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef enum logic [2:0] {
    CLEAR,
    LOAD,
    START,
    WAIT,
    READ,
    REPORT
  } fft_drv_state_t;

  function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] idx);
    return {idx[0], idx[1], idx[2], idx[3], idx[4], idx[5]};
  endfunction

endpackage

// File: rtl/fft_frame_driver_if.sv
// Sample stream, FFT core control/data and peak report bundled for the driver.
interface fft_frame_driver_if;
  import fft_pkg::*;

  logic [15:0]      sample_in;
  logic             sample_valid;
  logic             sample_ready;
  logic             fft_reset;
  logic             fft_load;
  logic [LOG2N-1:0] fft_load_address;
  logic [31:0]      fft_data_in;
  logic             fft_start;
  logic             fft_done;
  logic [31:0]      fft_data_out;
  logic [LOG2N-1:0] peak_bin;
  logic [16:0]      peak_mag;
  logic             result_valid;
  logic             busy;

  modport master (
    input  sample_in, sample_valid, fft_done, fft_data_out,
    output sample_ready, fft_reset, fft_load, fft_load_address, fft_data_in,
           fft_start, peak_bin, peak_mag, result_valid, busy
  );

  modport slave (
    output sample_in, sample_valid, fft_done, fft_data_out,
    input  sample_ready, fft_reset, fft_load, fft_load_address, fft_data_in,
           fft_start, peak_bin, peak_mag, result_valid, busy
  );

endinterface

// File: rtl/bin_magnitude.sv
// Cheap magnitude estimate |re|+|im| of one FFT result bin.
module bin_magnitude
  import fft_pkg::*;
(
  input  logic [31:0] bin_word,
  output logic [16:0] mag
);

  logic [15:0] re;
  logic [15:0] im;
  logic [15:0] abs_re;
  logic [15:0] abs_im;

  // Absolute values are kept unsigned so -32768 maps to 32768 without wrapping.
  always_comb begin
    re     = bin_word[RE_MSB:RE_LSB];
    im     = bin_word[IM_MSB:IM_LSB];
    abs_re = re[15] ? (~re + 16'd1) : re;
    abs_im = im[15] ? (~im + 16'd1) : im;
    mag    = {1'b0, abs_re} + {1'b0, abs_im};
  end

endmodule

// File: rtl/fft_frame_driver.sv
// Host sequencer for the 64-point FFT core: loads a frame, starts the core,
// scans the returned bins and reports the in-band magnitude peak.
module fft_frame_driver
  import fft_pkg::*;
#(
  parameter int BIT_REVERSE = 0,
  parameter int READ_LAT    = 1,
  parameter int MIN_BIN     = 1,
  parameter int MAX_BIN     = 31
) (
  input  logic               clk,
  input  logic               reset,
  fft_frame_driver_if.master bus
);

  fft_drv_state_t   state;
  fft_drv_state_t   next_state;

  logic [LOG2N-1:0] sample_count;
  logic [15:0]      read_offset;
  logic [15:0]      offset_now;
  logic [LOG2N-1:0] bin_index;
  logic [16:0]      bin_mag;
  logic [16:0]      max_mag;
  logic [LOG2N-1:0] max_bin;

  logic             handshake;
  logic             sample_now;
  logic             bin_last;
  logic             in_band;
  logic             new_max;

  logic             sample_ready;
  logic             busy;
  logic             fft_reset;

  logic             load_q;
  logic [LOG2N-1:0] load_address_q;
  logic [31:0]      data_in_q;
  logic             start_q;
  logic [LOG2N-1:0] peak_bin_q;
  logic [16:0]      peak_mag_q;
  logic             result_valid_q;

  bin_magnitude u_bin_magnitude (
    .bin_word (bus.fft_data_out),
    .mag      (bin_mag)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:  next_state = LOAD;
      LOAD:   if (handshake && (sample_count == LOG2N'(N - 1))) next_state = START;
      START:  next_state = WAIT;
      WAIT:   if (bus.fft_done) next_state = READ;
      READ:   if (bin_last) next_state = REPORT;
      REPORT: next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  // Ready is masked by reset so nothing is accepted while a frame is being discarded.
  always_comb begin
    sample_ready = (state == LOAD) && !reset;
    busy         = !sample_ready;
    fft_reset    = reset || (state == CLEAR);
    handshake    = bus.sample_valid && sample_ready;
  end

  // read_offset counts cycles since fft_done was first seen; bins arrive READ_LAT later.
  always_comb begin
    offset_now = (state == WAIT) ? 16'd0 : read_offset;
    sample_now = ((state == READ) && (read_offset >= 16'(READ_LAT))) ||
                 ((state == WAIT) && bus.fft_done && (READ_LAT == 0));
    bin_index  = LOG2N'(offset_now - 16'(READ_LAT));
    bin_last   = sample_now && (bin_index == LOG2N'(N - 1));
    in_band    = (int'(bin_index) >= MIN_BIN) && (int'(bin_index) <= MAX_BIN);
    new_max    = sample_now && in_band && (bin_mag > max_mag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_count   <= '0;
      read_offset    <= '0;
      max_mag        <= '0;
      max_bin        <= LOG2N'(MIN_BIN);
      load_q         <= 1'b0;
      load_address_q <= '0;
      data_in_q      <= '0;
      start_q        <= 1'b0;
      peak_bin_q     <= '0;
      peak_mag_q     <= '0;
      result_valid_q <= 1'b0;
    end else begin
      load_q         <= handshake;
      start_q        <= (state == START);
      result_valid_q <= bin_last;

      if (handshake) begin
        load_address_q <= (BIT_REVERSE != 0) ? bitrev6(sample_count) : sample_count;
        data_in_q      <= {bus.sample_in, 16'h0000};
        sample_count   <= sample_count + 1'b1;
      end

      case (state)
        CLEAR: begin
          sample_count <= '0;
          read_offset  <= '0;
          max_mag      <= '0;
          max_bin      <= LOG2N'(MIN_BIN);
        end
        WAIT:    if (bus.fft_done) read_offset <= 16'd1;
        READ:    read_offset <= read_offset + 16'd1;
        default: ;
      endcase

      // Strictly-greater update keeps the lowest index on ties.
      if (new_max) begin
        max_mag <= bin_mag;
        max_bin <= bin_index;
      end

      if (bin_last) begin
        peak_bin_q <= new_max ? bin_index : max_bin;
        peak_mag_q <= new_max ? bin_mag   : max_mag;
      end
    end
  end

  assign bus.sample_ready     = sample_ready;
  assign bus.busy             = busy;
  assign bus.fft_reset        = fft_reset;
  assign bus.fft_load         = load_q;
  assign bus.fft_load_address = load_address_q;
  assign bus.fft_data_in      = data_in_q;
  assign bus.fft_start        = start_q;
  assign bus.peak_bin         = peak_bin_q;
  assign bus.peak_mag         = peak_mag_q;
  assign bus.result_valid     = result_valid_q;

endmodule
